// File: rtl/wb_arbiter_pkg.sv
// Package: wb_arbiter_pkg
//  Shared micro-architecture constants and the writeback message type for the
//  execute-to-writeback fan-in arbiter.
//   UARCH_*   default pipe count and field widths
//   wb_msg_t  one writeback result {waddr, wdata, wen}
//   idx_bits  width of an encoded pipe index (at least 1 bit)
package wb_arbiter_pkg;

    localparam int UARCH_NUM_PIPES = 3;
    localparam int UARCH_ADDR_BITS = 5;
    localparam int UARCH_DATA_BITS = 32;

    typedef struct packed {
        logic [UARCH_ADDR_BITS-1:0] waddr;
        logic [UARCH_DATA_BITS-1:0] wdata;
        logic                       wen;
    } wb_msg_t;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arb_grant.sv
// Module: wb_arb_grant
//  Combinational N-way one-hot grant over a request vector.
//  Build option WB_ARB_RR_EN: defined -> round-robin search starting at ptr
//  with wrap; undefined -> fixed priority, lowest index wins (ptr ignored).
//   req    in   N    request per pipe
//   ptr    in   IW   first index to search (round-robin only)
//   grant  out  N    one-hot grant, zero when no request
//   idx    out  IW   encoded index of the granted pipe (0 when none)
module wb_arb_grant
    import wb_arbiter_pkg::*;
#(
    parameter int N  = UARCH_NUM_PIPES,
    parameter int IW = idx_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

`ifdef WB_ARB_RR_EN
    int   j;
    logic found;

    // Walk ptr, ptr+1, ... with wrap; first requester found wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                idx      = IW'(j);
                found    = 1'b1;
            end
        end
    end
`else
    logic found;
    logic unused_ptr;

    assign unused_ptr = ^ptr;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                idx      = IW'(k);
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Module: wb_arbiter
//  Merges completed results from p_num_pipes execute pipes into one registered
//  writeback stream. One pipe granted per cycle; 1-cycle ex->wb latency, full
//  throughput (drain and refill in the same edge).
//  Build option WB_ARB_RR_EN: round-robin grant with rotating ptr; when
//  undefined, fixed priority (lowest index) and no ptr register.
//   clk, rst   clock, asynchronous active-high reset
//   ex_val     in   per-pipe result valid
//   ex_rdy     out  per-pipe accept (one-hot or zero)
//   ex_waddr   in   per-pipe dest reg, pipe i at slice i
//   ex_wdata   in   per-pipe data, pipe i at slice i
//   ex_wen     in   per-pipe register-file write enable
//   wb_val     out  output register holds a result
//   wb_rdy     in   writeback consumes the result
//   wb_waddr/wb_wdata/wb_wen  out  registered result fields
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int p_num_pipes = UARCH_NUM_PIPES,
    parameter int p_addr_bits = UARCH_ADDR_BITS,
    parameter int p_data_bits = UARCH_DATA_BITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [p_num_pipes-1:0]           ex_val,
    output logic [p_num_pipes-1:0]           ex_rdy,
    input  logic [p_num_pipes*p_addr_bits-1:0] ex_waddr,
    input  logic [p_num_pipes*p_data_bits-1:0] ex_wdata,
    input  logic [p_num_pipes-1:0]           ex_wen,
    output logic                             wb_val,
    input  logic                             wb_rdy,
    output logic [p_addr_bits-1:0]           wb_waddr,
    output logic [p_data_bits-1:0]           wb_wdata,
    output logic                             wb_wen
);

    localparam int IW = idx_bits(p_num_pipes);

    // The message struct is sized by the package constants.
    if (p_addr_bits != UARCH_ADDR_BITS || p_data_bits != UARCH_DATA_BITS) begin : g_width_chk
        $error("wb_arbiter: field widths must match wb_arbiter_pkg constants");
    end

    logic [p_num_pipes-1:0] grant;
    logic [IW-1:0]          grant_idx;
    logic [IW-1:0]          ptr;
    logic                   space;
    logic                   xfer;
    wb_msg_t                sel;
    wb_msg_t                wb_q;

    wb_arb_grant #(.N(p_num_pipes), .IW(IW)) u_grant (
        .req   (ex_val),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Output is free if empty or being drained this cycle.
    assign space  = !wb_val || wb_rdy;
    assign ex_rdy = rst ? '0 : (grant & {p_num_pipes{space}});
    assign xfer   = |ex_rdy;

    // ex_rdy is one-hot, so an OR-style mux over it is sufficient.
    always_comb begin
        sel = '0;
        for (int i = 0; i < p_num_pipes; i++) begin
            if (ex_rdy[i]) begin
                sel.waddr = ex_waddr[i*p_addr_bits +: p_addr_bits];
                sel.wdata = ex_wdata[i*p_data_bits +: p_data_bits];
                sel.wen   = ex_wen[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_val <= 1'b0;
            wb_q   <= '0;
        end else if (xfer) begin
            wb_val <= 1'b1;
            wb_q   <= sel;
        end else if (wb_rdy) begin
            wb_val <= 1'b0;  // drain; fields keep last value
        end
    end

`ifdef WB_ARB_RR_EN
    // Next search starts just past the pipe that was served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (grant_idx == IW'(p_num_pipes-1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    logic unused_idx;

    assign ptr        = '0;
    assign unused_idx = ^grant_idx;
`endif

    assign wb_waddr = wb_q.waddr;
    assign wb_wdata = wb_q.wdata;
    assign wb_wen   = wb_q.wen;

endmodule
